// File: rtl/trng_pkg.sv
// Shared types and constants for the ring-oscillator TRNG sample controller.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    COLLECT = 3'd2,
    COND    = 3'd3,
    OUTPUT  = 3'd4,
    FAIL    = 3'd5
  } trng_state_t;

  localparam int WORD_W         = 8;
  localparam int SBOX_W         = 5;
  localparam int WARMUP_CYC_DEF = 64;
  localparam int SAMPLE_DIV_DEF = 4;
  localparam int RCT_LIMIT_DEF  = 16;

  // States in which the oscillators run and the sequencer counts as busy.
  function automatic logic run_state(input trng_state_t s);
    return (s == WARMUP) || (s == COLLECT) || (s == COND) || (s == OUTPUT);
  endfunction

endpackage

// File: rtl/trng_rct_monitor.sv
// Repetition-count health test: tracks the run length of identical raw bits.
module trng_rct_monitor #(
  parameter int RCT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_en,
  input  logic bit_in,
  output logic fail
);

  localparam int RW = $clog2(RCT_LIMIT + 1);

  logic [RW-1:0] run_q, run_d;
  logic          prev_q, prev_d;

  // A zero run means no history yet, so the next sample always starts a run of one.
  always_comb begin
    run_d  = run_q;
    prev_d = prev_q;
    fail   = 1'b0;
    if (clear) begin
      run_d  = '0;
      prev_d = 1'b0;
    end else if (sample_en) begin
      prev_d = bit_in;
      if ((run_q != '0) && (bit_in == prev_q)) begin
        if (run_q != RW'(RCT_LIMIT)) run_d = run_q + RW'(1);
      end else begin
        run_d = RW'(1);
      end
      fail = (run_d == RW'(RCT_LIMIT));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/trng_sample_ctrl.sv
// TRNG sequencer: RO warm-up, divided raw-bit sampling with RCT health test,
// 8-bit packing, s-box conditioning and valid/ready delivery.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int WARMUP_CYC = WARMUP_CYC_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int RCT_LIMIT  = RCT_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clr_fail,
  input  logic              raw_bit,
  output logic              ro_en_1,
  output logic              ro_en_2,
  output logic              sbox_act,
  output logic [SBOX_W-1:0] sbox_in,
  input  logic [SBOX_W-1:0] sbox_out,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              health_fail,
  output logic              busy
);

  localparam int CW = $clog2(WARMUP_CYC + 1);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int BW = $clog2(WORD_W + 1);

  trng_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              cond_ph_q, cond_ph_d;
  logic [WORD_W-1:0] rnd_data_q, rnd_data_d;
  logic              rnd_valid_q, rnd_valid_d;
  logic              health_fail_q, health_fail_d;
  logic              stop_pend_q, stop_pend_d;

  logic rct_clear, sample_en, rct_fail;

  trng_rct_monitor #(.RCT_LIMIT(RCT_LIMIT)) u_rct (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (rct_clear),
    .sample_en(sample_en),
    .bit_in   (raw_bit),
    .fail     (rct_fail)
  );

  always_comb begin
    rct_clear = (state_q == IDLE) && start && !stop;
    // A stop in the sampling clock wins, so the RCT never sees that sample.
    sample_en = (state_q == COLLECT) && (div_q == DW'(SAMPLE_DIV - 1)) && !stop;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    cond_ph_d     = cond_ph_q;
    rnd_data_d    = rnd_data_q;
    rnd_valid_d   = rnd_valid_q;
    health_fail_d = health_fail_q;
    stop_pend_d   = stop_pend_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = WARMUP;
          cnt_d       = '0;
          div_d       = '0;
          bitcnt_d    = '0;
          shift_d     = '0;
          stop_pend_d = 1'b0;
        end
      end
      WARMUP: begin
        if (stop)                              state_d = IDLE;
        else if (cnt_q == CW'(WARMUP_CYC - 1)) state_d = COLLECT;
        else                                   cnt_d   = cnt_q + CW'(1);
      end
      COLLECT: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          div_d = (div_q == DW'(SAMPLE_DIV - 1)) ? '0 : div_q + DW'(1);
          if (sample_en) begin
            shift_d  = {shift_q[WORD_W-2:0], raw_bit};
            bitcnt_d = bitcnt_q + BW'(1);
            if (rct_fail) begin
              state_d       = FAIL;
              health_fail_d = 1'b1;
            end else if (bitcnt_q == BW'(WORD_W - 1)) begin
              state_d   = COND;
              cond_ph_d = 1'b0;
            end
          end
        end
      end
      COND: begin
        if (stop) begin
          state_d   = IDLE;
          cond_ph_d = 1'b0;
        end else if (!cond_ph_q) begin
          cond_ph_d = 1'b1;
        end else begin
          cond_ph_d   = 1'b0;
          rnd_data_d  = shift_q ^ {{(WORD_W - SBOX_W){1'b0}}, sbox_out};
          rnd_valid_d = 1'b1;
          state_d     = OUTPUT;
        end
      end
      OUTPUT: begin
        if (stop) stop_pend_d = 1'b1;
        if (rnd_valid_q && rnd_ready) begin
          rnd_valid_d = 1'b0;
          bitcnt_d    = '0;
          div_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = (stop_pend_q || stop) ? IDLE : COLLECT;
        end
      end
      FAIL: begin
        if (clr_fail) begin
          state_d       = IDLE;
          health_fail_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      cond_ph_q     <= 1'b0;
      rnd_data_q    <= '0;
      rnd_valid_q   <= 1'b0;
      health_fail_q <= 1'b0;
      stop_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      cond_ph_q     <= cond_ph_d;
      rnd_data_q    <= rnd_data_d;
      rnd_valid_q   <= rnd_valid_d;
      health_fail_q <= health_fail_d;
      stop_pend_q   <= stop_pend_d;
    end
  end

  always_comb begin
    ro_en_1     = run_state(state_q);
    ro_en_2     = run_state(state_q);
    busy        = run_state(state_q);
    sbox_act    = (state_q == COND) && !cond_ph_q;
    sbox_in     = sbox_act ? shift_q[SBOX_W-1:0] : '0;
    rnd_data    = rnd_data_q;
    rnd_valid   = rnd_valid_q;
    health_fail = health_fail_q;
  end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed + randomized bench for trng_sample_ctrl with an s-box model and
// a word/RCT reference model derived from the sampling schedule.
module tb_trng_sample_ctrl;

  localparam int WARM = 64;
  localparam int DIV  = 4;
  localparam int LIM  = 16;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic       clk, rst_n, start, stop, clr_fail, raw_bit, rnd_ready;
  logic [4:0] sbox_out, sbox_in;
  logic [7:0] rnd_data;
  logic       ro_en_1, ro_en_2, sbox_act, rnd_valid, health_fail, busy;

  int   errors, checks, m_run;
  logic m_prev;
  bit   sbox_zero;

  trng_sample_ctrl #(.WARMUP_CYC(WARM), .SAMPLE_DIV(DIV), .RCT_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr_fail(clr_fail),
    .raw_bit(raw_bit), .ro_en_1(ro_en_1), .ro_en_2(ro_en_2), .sbox_act(sbox_act),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .health_fail(health_fail), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External s-box: result registered one clock after the activate strobe.
  always @(posedge clk) if (sbox_act) sbox_out <= sbox_zero ? 5'h00 : SBOX[sbox_in];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Hold raw_bit random between sample points; the sampled bit lands on the
  // last clock of each divider period.
  task automatic sample_bit(input logic b);
    for (int k = 0; k < DIV; k++) begin
      raw_bit = (k == DIV - 1) ? b : 1'($urandom);
      step();
    end
    m_run  = (m_run != 0 && b == m_prev) ? m_run + 1 : 1;
    m_prev = b;
    if (m_run >= LIM) begin
      chk("rct_hf",    32'(health_fail), 1);
      chk("rct_ro",    32'(ro_en_1),     0);
      chk("rct_ro2",   32'(ro_en_2),     0);
      chk("rct_busy",  32'(busy),        0);
      chk("rct_nvld",  32'(rnd_valid),   0);
    end else begin
      chk("smp_busy",  32'(busy),        1);
      chk("smp_hf",    32'(health_fail), 0);
      chk("smp_nvld",  32'(rnd_valid),   0);
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    m_run = 0;
    chk("wu_ro1",  32'(ro_en_1), 1);
    chk("wu_ro2",  32'(ro_en_2), 1);
    chk("wu_busy", 32'(busy),    1);
    for (int i = 0; i < WARM; i++) begin
      raw_bit = 1'($urandom);
      step();
      chk("wu_nvld", 32'(rnd_valid), 0);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int hold, input bit stop_out);
    logic [7:0] exp;
    for (int i = 7; i >= 0; i--) sample_bit(w[i]);
    exp = w ^ {3'b000, (sbox_zero ? 5'h00 : SBOX[w[4:0]])};
    chk("cond_act", 32'(sbox_act), 1);
    chk("cond_in",  32'(sbox_in),  32'(w[4:0]));
    rnd_ready = (hold == 0);
    step();
    chk("cond2_act", 32'(sbox_act),  0);
    chk("cond2_vld", 32'(rnd_valid), 0);
    step();
    chk("out_vld",  32'(rnd_valid), 1);
    chk("out_data", 32'(rnd_data),  32'(exp));
    for (int k = 0; k < hold; k++) begin
      stop = stop_out && (k == 0);
      step();
      stop = 1'b0;
      chk("hold_vld",  32'(rnd_valid), 1);
      chk("hold_data", 32'(rnd_data),  32'(exp));
    end
    rnd_ready = 1'b1;
    step();
    chk("hs_vld",  32'(rnd_valid), 0);
    chk("hs_busy", 32'(busy),      stop_out ? 0 : 1);
    chk("hs_ro",   32'(ro_en_1),   stop_out ? 0 : 1);
  endtask

  initial begin
    errors = 0; checks = 0; m_run = 0; m_prev = 1'b0; sbox_zero = 1'b1;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr_fail = 1'b0;
    raw_bit = 1'b0; rnd_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_ro1",  32'(ro_en_1),     0);
    chk("rst_ro2",  32'(ro_en_2),     0);
    chk("rst_busy", 32'(busy),        0);
    chk("rst_vld",  32'(rnd_valid),   0);
    chk("rst_data", 32'(rnd_data),    0);
    chk("rst_hf",   32'(health_fail), 0);
    chk("rst_act",  32'(sbox_act),    0);
    chk("rst_sin",  32'(sbox_in),     0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Known pattern, s-box output forced to zero, then with the s-box model and backpressure
    start_run();
    send_word(8'hB2, 0, 1'b0);
    sbox_zero = 1'b0;
    send_word(8'hB2, 10, 1'b0);

    // Random words (never all-equal, so no run can reach the limit) and random backpressure
    for (int n = 0; n < 6; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      if (w == 8'h00 || w == 8'hFF) w = 8'h5A;
      send_word(w, int'($urandom_range(0, 3)), 1'b0);
    end
    // Stop while a word is waiting: word still delivered, then idle
    send_word(8'h3C, 3, 1'b1);

    // Stuck-at-1: first word delivered, 16th sample trips the health test
    start_run();
    send_word(8'hFF, 0, 1'b0);
    for (int i = 0; i < 8; i++) sample_bit(1'b1);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("fail_ign_busy", 32'(busy),        0);
    chk("fail_sticky",   32'(health_fail), 1);
    clr_fail = 1'b1;
    step();
    clr_fail = 1'b0;
    chk("clr_hf",   32'(health_fail), 0);
    chk("clr_busy", 32'(busy),        0);
    chk("clr_ro",   32'(ro_en_1),     0);

    // Stop mid-COLLECT
    start_run();
    for (int i = 0; i < 3; i++) sample_bit(1'($urandom));
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stopc_busy", 32'(busy),    0);
    chk("stopc_ro",   32'(ro_en_2), 0);
    for (int i = 0; i < 30; i++) begin
      raw_bit = 1'($urandom);
      step();
      chk("stopc_nvld", 32'(rnd_valid), 0);
    end

    // Start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy),    0);
    chk("ss_ro",   32'(ro_en_1), 0);
    step();
    chk("ss_busy2", 32'(busy), 0);

    // Reset during COND
    start_run();
    for (int i = 0; i < 8; i++) sample_bit(1'($urandom));
    chk("g_cond_act", 32'(sbox_act), 1);
    rst_n = 1'b0;
    step();
    chk("grst_ro1",  32'(ro_en_1),     0);
    chk("grst_ro2",  32'(ro_en_2),     0);
    chk("grst_busy", 32'(busy),        0);
    chk("grst_act",  32'(sbox_act),    0);
    chk("grst_sin",  32'(sbox_in),     0);
    chk("grst_vld",  32'(rnd_valid),   0);
    chk("grst_data", 32'(rnd_data),    0);
    chk("grst_hf",   32'(health_fail), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("grst_nvld", 32'(rnd_valid), 0);
      chk("grst_idle", 32'(busy),      0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
